layer_arbiter: RTL and testbench

//  Configurable pixel-layer arbiter/sequencer between the sprite/object drawers and the VGA DAC path.

---
 rtl/layer_pkg.sv | 39 +++
 rtl/layer_prio_select.sv | 32 +++
 rtl/layer_arbiter.sv | 150 +++++++++++++++
 tb/tb_layer_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/layer_pkg.sv
// Shared types and sizing for the pixel-layer arbiter.
//  NUM_LAYERS  : number of object layers
//  RGB_W       : pixel colour width
//  BLINK_DIV_W : frame-counter width, blink phase is its MSB
//  LAYER_IDX_W : width of a layer index / priority value
package layer_pkg;

  localparam int unsigned NUM_LAYERS  = 4;
  localparam int unsigned RGB_W       = 8;
  localparam int unsigned BLINK_DIV_W = 4;
  localparam int unsigned LAYER_IDX_W = $clog2(NUM_LAYERS);

  typedef struct packed {
    logic [LAYER_IDX_W-1:0] prio;
    logic                   enable;
    logic                   blink;
  } layer_cfg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } cfg_state_t;

  // Power-up table entry: priority equals index, visible, not blinking.
  function automatic layer_cfg_t default_cfg(input int unsigned idx);
    layer_cfg_t c;
    c.prio   = LAYER_IDX_W'(idx);
    c.enable = 1'b1;
    c.blink  = 1'b0;
    return c;
  endfunction

  // True when two or more bits are set.
  function automatic logic multi_hot(input logic [NUM_LAYERS-1:0] v);
    return (v & (v - NUM_LAYERS'(1))) != '0;
  endfunction

endpackage

// File: rtl/layer_prio_select.sv
// Combinational winner pick: lowest priority value among visible layers,
// equal priorities resolved toward the lower layer index.
//  vis      : visible-request mask
//  prio     : per-layer priority (0 = highest)
//  winLayer : winning layer index (0 when none)
//  winValid : a visible layer exists
module layer_prio_select
  import layer_pkg::*;
(
  input  logic [NUM_LAYERS-1:0]                  vis,
  input  logic [NUM_LAYERS-1:0][LAYER_IDX_W-1:0] prio,
  output logic [LAYER_IDX_W-1:0]                 winLayer,
  output logic                                   winValid
);

  logic [LAYER_IDX_W-1:0] best;

  // Strict less-than keeps the earlier (lower) index on ties.
  always_comb begin
    winLayer = '0;
    winValid = 1'b0;
    best     = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (vis[i] && (!winValid || (prio[i] < best))) begin
        winValid = 1'b1;
        winLayer = LAYER_IDX_W'(i);
        best     = prio[i];
      end
    end
  end

endmodule

// File: rtl/layer_arbiter.sv
// Pixel-layer arbiter: masks layer requests with the active table, picks the
// winning colour with a fixed 2-cycle latency, and tracks overlaps. The table
// is written into a shadow copy and swapped in only at frame start.
//  clk, resetN        : pixel clock, async active-low reset
//  startOfFrame       : pulse on the first pixel of a frame
//  drawReq/layerRGB   : per-layer request and packed colours
//  backGroundRGB      : colour when no layer wins
//  cfg_*              : valid/ready table write (layer, prio, enable, blink)
//  RGBOut/winLayer/winValid/collision : registered pixel result
//  frameCollision     : layers involved in any overlap this frame
module layer_arbiter
  import layer_pkg::*;
(
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic [NUM_LAYERS-1:0]         drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0]   layerRGB,
  input  logic [RGB_W-1:0]              backGroundRGB,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [LAYER_IDX_W-1:0]        cfg_layer,
  input  logic [LAYER_IDX_W-1:0]        cfg_prio,
  input  logic                          cfg_enable,
  input  logic                          cfg_blink,
  output logic [RGB_W-1:0]              RGBOut,
  output logic [LAYER_IDX_W-1:0]        winLayer,
  output logic                          winValid,
  output logic                          collision,
  output logic [NUM_LAYERS-1:0]         frameCollision
);

  cfg_state_t                            state, state_nxt;
  layer_cfg_t                            active_tbl [NUM_LAYERS];
  layer_cfg_t                            shadow_tbl [NUM_LAYERS];
  logic [BLINK_DIV_W-1:0]                frame_cnt, frame_cnt_inc;
  logic                                  phase;
  logic                                  cfg_accept;
  logic [NUM_LAYERS-1:0]                 vis_c, vis_q;
  logic                                  coll_c;
  logic [NUM_LAYERS-1:0][LAYER_IDX_W-1:0] prio_q;
  logic [NUM_LAYERS*RGB_W-1:0]           rgb_q;
  logic [RGB_W-1:0]                      bg_q;
  logic [LAYER_IDX_W-1:0]                sel_layer;
  logic                                  sel_valid;

  assign cfg_accept = cfg_valid & cfg_ready;

  // Config FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // A write landing together with startOfFrame goes straight to COMMIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_accept)   state_nxt = startOfFrame ? COMMIT : PENDING;
      PENDING: if (startOfFrame) state_nxt = COMMIT;
      COMMIT:                    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Ready is dropped for exactly the COMMIT cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cfg_ready <= 1'b1;
    else         cfg_ready <= (state_nxt != COMMIT);
  end

  // Shadow takes writes; active is refreshed from shadow during COMMIT.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        shadow_tbl[i] <= default_cfg(i);
        active_tbl[i] <= default_cfg(i);
      end
    end else begin
      if (cfg_accept) begin
        shadow_tbl[cfg_layer] <= '{prio: cfg_prio, enable: cfg_enable, blink: cfg_blink};
      end
      if (state == COMMIT) active_tbl <= shadow_tbl;
    end
  end

  // Frame counter; the frame's first pixel already sees the new phase.
  assign frame_cnt_inc = frame_cnt + BLINK_DIV_W'(1);
  assign phase = startOfFrame ? frame_cnt_inc[BLINK_DIV_W-1] : frame_cnt[BLINK_DIV_W-1];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           frame_cnt <= '0;
    else if (startOfFrame) frame_cnt <= frame_cnt_inc;
  end

  // Visible-request mask from the active table.
  always_comb begin
    vis_c = '0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      vis_c[i] = drawReq[i] & active_tbl[i].enable & ~(active_tbl[i].blink & phase);
    end
  end

  assign coll_c = multi_hot(vis_c);

  // S1: capture the pixel together with the priorities it was masked under.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vis_q <= '0;
      rgb_q <= '0;
      bg_q  <= '0;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) prio_q[i] <= LAYER_IDX_W'(i);
    end else begin
      vis_q <= vis_c;
      rgb_q <= layerRGB;
      bg_q  <= backGroundRGB;
      for (int unsigned i = 0; i < NUM_LAYERS; i++) prio_q[i] <= active_tbl[i].prio;
    end
  end

  layer_prio_select u_sel (
    .vis      (vis_q),
    .prio     (prio_q),
    .winLayer (sel_layer),
    .winValid (sel_valid)
  );

  // S2: registered pixel result.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut    <= '0;
      winLayer  <= '0;
      winValid  <= 1'b0;
      collision <= 1'b0;
    end else begin
      RGBOut    <= sel_valid ? rgb_q[sel_layer*RGB_W +: RGB_W] : bg_q;
      winLayer  <= sel_layer;
      winValid  <= sel_valid;
      collision <= multi_hot(vis_q);
    end
  end

  // Per-frame overlap summary; the frame's first pixel starts a fresh sum.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)           frameCollision <= '0;
    else if (startOfFrame) frameCollision <= coll_c ? vis_c : '0;
    else if (coll_c)       frameCollision <= frameCollision | vis_c;
  end

endmodule

// File: tb/tb_layer_arbiter.sv
// Randomized self-checking bench for layer_arbiter with a cycle-level
// reference model of the layer table, blink phase and winner rules.
module tb_layer_arbiter;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [3:0]  drawReq = '0;
  logic [31:0] layerRGB = '0;
  logic [7:0]  backGroundRGB = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_layer = '0;
  logic [1:0]  cfg_prio = '0;
  logic        cfg_enable = 1'b0;
  logic        cfg_blink = 1'b0;
  logic [7:0]  RGBOut;
  logic [1:0]  winLayer;
  logic        winValid;
  logic        collision;
  logic [3:0]  frameCollision;

  int errors = 0;
  int checks = 0;

  layer_arbiter dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .drawReq(drawReq), .layerRGB(layerRGB), .backGroundRGB(backGroundRGB),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_layer(cfg_layer),
    .cfg_prio(cfg_prio), .cfg_enable(cfg_enable), .cfg_blink(cfg_blink),
    .RGBOut(RGBOut), .winLayer(winLayer), .winValid(winValid),
    .collision(collision), .frameCollision(frameCollision)
  );

  always #5 clk = ~clk;

  // Reference model state: tables, pending flag, commit cycle, frame count.
  int   m_pr [4], m_en [4], m_bl [4];
  int   s_pr [4], s_en [4], s_bl [4];
  bit   m_pend, m_commit;
  int   m_cnt;
  logic [3:0] m_fc;
  // Expected results for the pixel one (a) and two (b) cycles back.
  logic [31:0] ea_rgb, ea_lay, ea_val, ea_col;
  logic [31:0] eb_rgb, eb_lay, eb_val, eb_col;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pr[i] = i; m_en[i] = 1; m_bl[i] = 0;
      s_pr[i] = i; s_en[i] = 1; s_bl[i] = 0;
    end
    m_pend = 0; m_commit = 0; m_cnt = 0; m_fc = '0;
    ea_rgb = 0; ea_lay = 0; ea_val = 0; ea_col = 0;
    eb_rgb = 0; eb_lay = 0; eb_val = 0; eb_col = 0;
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_step();
    bit ph, found, nc;
    bit [3:0] v;
    int n, w;
    ph = startOfFrame ? (((m_cnt + 1) % 16) >= 8) : (m_cnt >= 8);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      v[i] = drawReq[i] && (m_en[i] != 0) && !((m_bl[i] != 0) && ph);
      n += int'(v[i]);
    end
    found = 0; w = 0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 4; i++)
        if (!found && v[i] && m_pr[i] == p) begin found = 1; w = i; end
    eb_rgb = ea_rgb; eb_lay = ea_lay; eb_val = ea_val; eb_col = ea_col;
    ea_rgb = found ? 32'(layerRGB[w*8 +: 8]) : 32'(backGroundRGB);
    ea_lay = w;
    ea_val = 32'(found);
    ea_col = 32'(n >= 2);
    if (startOfFrame) m_fc = '0;
    if (n >= 2) m_fc = m_fc | v;
    if (cfg_valid && !m_commit) begin
      s_pr[cfg_layer] = int'(cfg_prio);
      s_en[cfg_layer] = int'(cfg_enable);
      s_bl[cfg_layer] = int'(cfg_blink);
      m_pend = 1;
    end
    if (m_commit) begin
      m_pr = s_pr; m_en = s_en; m_bl = s_bl;
    end
    nc = startOfFrame && m_pend && !m_commit;
    if (nc) m_pend = 0;
    m_commit = nc;
    if (startOfFrame) m_cnt = (m_cnt + 1) % 16;
  endtask

  // One pixel: check what is on the outputs, then drive the next pixel.
  task automatic step(input logic sof, input logic [3:0] req, input logic [7:0] bg,
                      input logic cv, input logic [1:0] cl, input logic [1:0] cp,
                      input logic ce, input logic cb);
    @(negedge clk);
    chk("rgb",    32'(RGBOut),         eb_rgb);
    chk("layer",  32'(winLayer),       eb_lay);
    chk("valid",  32'(winValid),       eb_val);
    chk("coll",   32'(collision),      eb_col);
    chk("fcoll",  32'(frameCollision), 32'(m_fc));
    chk("ready",  32'(cfg_ready),      32'(!m_commit));
    startOfFrame = sof; drawReq = req; layerRGB = $urandom; backGroundRGB = bg;
    cfg_valid = cv; cfg_layer = cl; cfg_prio = cp; cfg_enable = ce; cfg_blink = cb;
    model_step();
  endtask

  task automatic idle(input logic sof, input logic [3:0] req);
    step(sof, req, 8'($urandom), 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 1'b0; drawReq = '0; layerRGB = '0; backGroundRGB = '0; cfg_valid = 1'b0;
    #1;
    chk("rst_rgb",   32'(RGBOut),         32'd0);
    chk("rst_layer", 32'(winLayer),       32'd0);
    chk("rst_valid", 32'(winValid),       32'd0);
    chk("rst_coll",  32'(collision),      32'd0);
    chk("rst_fcoll", 32'(frameCollision), 32'd0);
    chk("rst_ready", 32'(cfg_ready),      32'd1);
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
    model_step();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Default table: layers 1 and 2 overlap, layer 1 wins.
    idle(1'b1, 4'b0110);
    idle(1'b0, 4'b0000);
    @(posedge clk); #1;
    chk("t1_layer", 32'(winLayer),  32'd1);
    chk("t1_valid", 32'(winValid),  32'd1);
    chk("t1_coll",  32'(collision), 32'd1);

    // Nothing requesting: background passes through.
    step(1'b0, 4'b0000, 8'hE0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    idle(1'b0, 4'b0000);
    @(posedge clk); #1;
    chk("t2_rgb",   32'(RGBOut),   32'hE0);
    chk("t2_valid", 32'(winValid), 32'd0);

    // Mid-frame write of layer 3 to top priority, committed at next frame.
    idle(1'b0, 4'b1001);
    step(1'b0, 4'b1001, 8'h11, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) idle(1'b0, 4'b1001);
    for (int c = 0; c < 8; c++) idle(c == 0, 4'b1001);

    // Two writes to layer 2 (last wins), plus one in the startOfFrame cycle.
    step(1'b0, 4'b0101, 8'h22, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0);
    step(1'b0, 4'b0101, 8'h22, 1'b1, 2'd2, 2'd3, 1'b1, 1'b0);
    idle(1'b0, 4'b0101);
    step(1'b1, 4'b0101, 8'h22, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) idle(1'b0, 4'($urandom));

    // Blink on layer 1 alone across 34 short frames from a fresh counter.
    do_reset();
    step(1'b0, 4'b0010, 8'h33, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1);
    for (int f = 0; f < 34; f++)
      for (int c = 0; c < 4; c++) idle(c == 0, 4'b0010);

    // One overlap of layers 0 and 2, then a clean frame.
    for (int c = 0; c < 6; c++) idle(c == 0, (c == 2) ? 4'b0101 : 4'b0000);
    @(posedge clk); #1;
    chk("t6_fcoll", 32'(frameCollision), 32'h5);
    for (int c = 0; c < 4; c++) idle(c == 0, 4'b0000);

    // Reset while a write is pending: table must be back at defaults.
    step(1'b0, 4'b0000, 8'h44, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0);
    idle(1'b0, 4'b0000);
    do_reset();
    for (int c = 0; c < 8; c++) idle(c == 0, 4'b1001);

    // Random frames with random traffic and config writes.
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(6, 20);
      for (int c = 0; c < len; c++)
        step(c == 0, 4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
             2'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0));
      if (f == 20) do_reset();
    end
    for (int c = 0; c < 4; c++) idle(1'b0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
